// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit period, frame constants and FSM state types.
// Build option: define UART_PARITY_EN to add the optional parity bit to TX and RX frames.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
  localparam int unsigned DATA_BITS            = 8;
  localparam logic        IDLE_LEVEL           = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

`ifdef UART_PARITY_EN
  // Parity bit for a data byte: XOR of the bits (even), inverted for odd parity.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
`endif

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs while enabled, ticks at mid-bit and at end of each bit,
// and wraps so consecutive bits are timed back to back. Held at zero when disabled.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mid_tick,
  output logic end_tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] END_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Cycle counter within the current bit; restarts at zero on every bit boundary.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == END_CNT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Tick decode.
  always_comb begin
    mid_tick = en && (cnt == MID_CNT);
    end_tick = en && (cnt == END_CNT);
  end

endmodule

// File: rtl/uart_rx_tx.sv
// Full-duplex UART: independent transmitter and receiver, each timed by its own
// uart_bit_timer. Receiver keeps a four-byte history (r1 newest).
// Build option: define UART_PARITY_EN to honour parity_en/parity_kind; otherwise
// frames are always start + 8 data + stop and the parity inputs are ignored.
module uart_rx_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic        start,
  input  logic        parity_en,
  input  logic        parity_kind,
  input  logic        rxd,
  output logic        txd,
  output logic        flag,
  output logic        ft,
  output logic [7:0]  r1,
  output logic [7:0]  r2,
  output logic [7:0]  r3,
  output logic [7:0]  r4,
  output logic        fr
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic unused_inputs;
`ifdef UART_PARITY_EN
  assign unused_inputs = ^data[15:8];
`else
  assign unused_inputs = ^{data[15:8], parity_en, parity_kind};
`endif

  // ---------------------------------------------------------------- TX
  tx_state_t  tx_state, tx_state_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic       ft_n;
  logic       start_q;
  logic       start_rise;
  logic       tx_end;
  logic       unused_tx_mid;
`ifdef UART_PARITY_EN
  logic       tx_pen, tx_pen_n;
  logic       tx_par, tx_par_n;
`endif

  assign start_rise = start && !start_q;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (tx_state != TX_IDLE),
    .mid_tick (unused_tx_mid),
    .end_tick (tx_end)
  );

  // TX state, shift register, bit counter and start edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_bit   <= '0;
      ft       <= 1'b0;
      start_q  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_pen   <= 1'b0;
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_shift <= tx_shift_n;
      tx_bit   <= tx_bit_n;
      ft       <= ft_n;
      start_q  <= start;
`ifdef UART_PARITY_EN
      tx_pen   <= tx_pen_n;
      tx_par   <= tx_par_n;
`endif
    end
  end

  // TX next state and line level; frame settings are latched on the start edge.
  always_comb begin
    tx_state_n = tx_state;
    tx_shift_n = tx_shift;
    tx_bit_n   = tx_bit;
    ft_n       = 1'b0;
    txd        = IDLE_LEVEL;
`ifdef UART_PARITY_EN
    tx_pen_n   = tx_pen;
    tx_par_n   = tx_par;
`endif
    case (tx_state)
      TX_IDLE: begin
        if (start_rise) begin
          tx_state_n = TX_START;
          tx_shift_n = data[7:0];
          tx_bit_n   = '0;
`ifdef UART_PARITY_EN
          tx_pen_n   = parity_en;
          tx_par_n   = parity_bit(data[7:0], parity_kind);
`endif
        end
      end
      TX_START: begin
        txd = ~IDLE_LEVEL;
        if (tx_end) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        txd = tx_shift[0];
        if (tx_end) begin
          tx_shift_n = tx_shift >> 1;
          if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_state_n = tx_pen ? TX_PARITY : TX_STOP;
`else
            tx_state_n = TX_STOP;
`endif
          end else begin
            tx_bit_n = tx_bit + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        txd = tx_par;
        if (tx_end) tx_state_n = TX_STOP;
      end
`endif
      TX_STOP: begin
        txd = IDLE_LEVEL;
        if (tx_end) begin
          tx_state_n = TX_IDLE;
          ft_n       = 1'b1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign flag = (tx_state != TX_IDLE);

  // ---------------------------------------------------------------- RX
  rx_state_t  rx_state, rx_state_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic       fr_n;
  logic       rx_sync1, rx_sync2, rx_prev;
  logic       rx_fall;
  logic       rx_mid, rx_end;
`ifdef UART_PARITY_EN
  logic       rx_pen, rx_pen_n;
  logic       rx_kind, rx_kind_n;
  logic       rx_err, rx_err_n;
`endif

  assign rx_fall = rx_prev && !rx_sync2;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (rx_state != RX_IDLE),
    .mid_tick (rx_mid),
    .end_tick (rx_end)
  );

  // Synchronizer, RX state, assembled byte and received-byte history.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync1 <= IDLE_LEVEL;
      rx_sync2 <= IDLE_LEVEL;
      rx_prev  <= IDLE_LEVEL;
      rx_state <= RX_IDLE;
      rx_shift <= '0;
      rx_bit   <= '0;
      fr       <= 1'b0;
      r1       <= '0;
      r2       <= '0;
      r3       <= '0;
      r4       <= '0;
`ifdef UART_PARITY_EN
      rx_pen   <= 1'b0;
      rx_kind  <= 1'b0;
      rx_err   <= 1'b0;
`endif
    end else begin
      rx_sync1 <= rxd;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
      rx_state <= rx_state_n;
      rx_shift <= rx_shift_n;
      rx_bit   <= rx_bit_n;
      fr       <= fr_n;
      if (fr_n) begin
        r1 <= rx_shift;
        r2 <= r1;
        r3 <= r2;
        r4 <= r3;
      end
`ifdef UART_PARITY_EN
      rx_pen   <= rx_pen_n;
      rx_kind  <= rx_kind_n;
      rx_err   <= rx_err_n;
`endif
    end
  end

  // RX next state; every bit is judged at its midpoint, transitions on bit end,
  // except the stop bit which releases the receiver right at its midpoint.
  always_comb begin
    rx_state_n = rx_state;
    rx_shift_n = rx_shift;
    rx_bit_n   = rx_bit;
    fr_n       = 1'b0;
`ifdef UART_PARITY_EN
    rx_pen_n   = rx_pen;
    rx_kind_n  = rx_kind;
    rx_err_n   = rx_err;
`endif
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_n = RX_START;
          rx_bit_n   = '0;
`ifdef UART_PARITY_EN
          rx_pen_n   = parity_en;
          rx_kind_n  = parity_kind;
          rx_err_n   = 1'b0;
`endif
        end
      end
      RX_START: begin
        if (rx_mid && (rx_sync2 == IDLE_LEVEL)) begin
          rx_state_n = RX_IDLE;
        end else if (rx_end) begin
          rx_state_n = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_mid) rx_shift_n = {rx_sync2, rx_shift[7:1]};
        if (rx_end) begin
          if (rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_state_n = rx_pen ? RX_PARITY : RX_STOP;
`else
            rx_state_n = RX_STOP;
`endif
          end else begin
            rx_bit_n = rx_bit + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_mid) rx_err_n = (rx_sync2 != parity_bit(rx_shift, rx_kind));
        if (rx_end) rx_state_n = RX_STOP;
      end
`endif
      RX_STOP: begin
        if (rx_mid) begin
          rx_state_n = RX_IDLE;
`ifdef UART_PARITY_EN
          fr_n = (rx_sync2 == IDLE_LEVEL) && !rx_err;
`else
          fr_n = (rx_sync2 == IDLE_LEVEL);
`endif
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_tx.sv
// Scoreboard bench for uart_rx_tx: stimulus pushes expected TX frames / RX bytes,
// independent monitors decode txd and react to fr pulses.
module tb_uart_rx_tx;

  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic        start = 1'b0;
  logic        parity_en = 1'b0;
  logic        parity_kind = 1'b0;
  logic        rxd = 1'b1;
  logic        txd, flag, ft, fr;
  logic [7:0]  r1, r2, r3, r4;

  uart_rx_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .data(data), .start(start),
    .parity_en(parity_en), .parity_kind(parity_kind), .rxd(rxd),
    .txd(txd), .flag(flag), .ft(ft),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4), .fr(fr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [10:0] bits;
    int          n;
  } tx_frame_t;

  tx_frame_t  tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] hist [4];
  int ft_count = 0, fr_count = 0, tx_done_exp = 0, rx_good_exp = 0;

  // Parity by counting ones: even parity makes the total even; odd inverts.
  function automatic logic par_of(input logic [7:0] d, input bit kind);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return ((ones % 2) == 1) ^ kind;
  endfunction

  // Line bits in transmission order (bit 0 first).
  function automatic tx_frame_t model_tx(input logic [7:0] d, input bit pen, input bit kind);
    tx_frame_t f;
    f.bits = '0;
    for (int i = 0; i < 8; i++) f.bits[1 + i] = d[i];
    if (PAR_BUILT && pen) begin
      f.bits[9]  = par_of(d, kind);
      f.bits[10] = 1'b1;
      f.n = 11;
    end else begin
      f.bits[9] = 1'b1;
      f.n = 10;
    end
    return f;
  endfunction

  // TX monitor: decode each frame at bit midpoints, measure flag, check ft at flag fall.
  initial begin
    tx_frame_t   f;
    logic [10:0] got;
    int          fcnt;
    bit          ab;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || txd !== 1'b0) continue;
      if (tx_q.size() == 0) begin
        check("tx_unexpected_frame", {31'b0, txd}, 32'd1);
        for (int w = 0; w < 400 && flag === 1'b1; w++) @(negedge clk);
        continue;
      end
      f = tx_q.pop_front();
      got = '0;
      fcnt = 0;
      ab = 1'b0;
      for (int k = 0; k < f.n && !ab; k++) begin
        for (int s = 0; s < ((k == 0) ? CPB / 2 : CPB); s++) begin
          if (flag === 1'b1) fcnt++;
          if (rst === 1'b1) ab = 1'b1;
          @(negedge clk);
        end
        if (rst === 1'b1) ab = 1'b1;
        got[k] = txd;
      end
      for (int w = 0; w < 40 && flag === 1'b1 && !ab; w++) begin
        fcnt++;
        if (rst === 1'b1) ab = 1'b1;
        @(negedge clk);
      end
      if (rst === 1'b1) ab = 1'b1;
      if (!ab) begin
        check("tx_frame_bits", {21'b0, got}, {21'b0, f.bits});
        check("tx_flag_cycles", fcnt, f.n * CPB);
        check("tx_ft_at_flag_fall", {31'b0, ft}, 32'd1);
      end
    end
  end

  // RX monitor and pulse counters.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (ft === 1'b1) ft_count++;
      if (fr === 1'b1) begin
        fr_count++;
        if (rx_q.size() == 0) begin
          check("rx_fr_without_frame", {31'b0, fr}, 32'd0);
        end else begin
          b = rx_q.pop_front();
          hist[3] = hist[2];
          hist[2] = hist[1];
          hist[1] = hist[0];
          hist[0] = b;
          check("rx_history", {r1, r2, r3, r4}, {hist[0], hist[1], hist[2], hist[3]});
        end
      end
    end
  end

  // mode: 0 normal, 1 re-pulse start while busy, 2 hold start high past the frame.
  task automatic send_tx(input logic [15:0] d, input bit pen, input bit kind,
                         input int mode, input bit chg_par);
    logic seen_low;
    @(negedge clk);
    data = d;
    parity_en = pen;
    parity_kind = kind;
    start = 1'b1;
    tx_q.push_back(model_tx(d[7:0], pen, kind));
    @(negedge clk);
    check("tx_go_txd", {31'b0, txd}, 32'd0);
    check("tx_go_flag", {31'b0, flag}, 32'd1);
    data = 16'($urandom);
    if (chg_par) begin
      parity_en = 1'($urandom);
      parity_kind = 1'($urandom);
    end
    repeat (3) @(negedge clk);
    if (mode != 2) start = 1'b0;
    if (mode == 1) begin
      repeat (40) @(negedge clk);
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 400 && flag === 1'b1; i++) @(negedge clk);
    check("tx_done_timeout", {31'b0, flag}, 32'd0);
    tx_done_exp++;
    if (mode == 2) begin
      seen_low = 1'b0;
      repeat (3 * CPB) begin
        @(negedge clk);
        if (txd !== 1'b1) seen_low = 1'b1;
      end
      check("tx_hold_no_retrigger", {31'b0, seen_low}, 32'd0);
      start = 1'b0;
    end
    repeat ($urandom_range(2, 6)) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit pen, input bit kind,
                         input bit bad_par, input bit bad_stop);
    bit has_par;
    has_par = PAR_BUILT && pen;
    if (!bad_stop && !(has_par && bad_par)) begin
      rx_q.push_back(b);
      rx_good_exp++;
    end
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (has_par) begin
      rxd = par_of(b, kind) ^ bad_par;
      repeat (CPB) @(negedge clk);
    end
    rxd = !bad_stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (CPB / 2 + $urandom_range(0, 8)) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  frc, ftc;
    bit  pen, kind;
    hist = '{default: 8'h00};

    repeat (3) @(negedge clk);
    check("rst_txd", {31'b0, txd}, 32'd1);
    check("rst_flag", {31'b0, flag}, 32'd0);
    check("rst_ft", {31'b0, ft}, 32'd0);
    check("rst_fr", {31'b0, fr}, 32'd0);
    check("rst_hist", {r1, r2, r3, r4}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Transmitter, one at a time.
    send_tx(16'hAB55, 1'b0, 1'b0, 0, 1'b1);
    send_tx(16'h0007, 1'b1, 1'b0, 0, 1'b1);
    send_tx(16'h0007, 1'b1, 1'b1, 0, 1'b1);
    send_tx(16'($urandom), 1'($urandom), 1'($urandom), 1, 1'b1);
    send_tx(16'($urandom), 1'($urandom), 1'($urandom), 2, 1'b1);
    for (int i = 0; i < 6; i++)
      send_tx(16'($urandom), 1'($urandom), 1'($urandom), 0, 1'b1);

    // Receiver, directed history.
    parity_en = 1'b0;
    parity_kind = 1'b0;
    repeat (2) @(negedge clk);
    send_rx(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_rx(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    send_rx(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    send_rx(8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rx_four_frames", fr_count, 32'd4);
    send_rx(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rx_after_five", {r1, r2, r3, r4}, 32'h55443322);

    // Framing error and a short glitch leave the history alone.
    frc = fr_count;
    send_rx(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("rx_bad_no_fr", fr_count, frc);
    check("rx_bad_hist", {r1, r2, r3, r4}, 32'h55443322);

    // Full duplex with a fixed random parity setting.
    pen = 1'($urandom);
    kind = 1'($urandom);
    parity_en = pen;
    parity_kind = kind;
    repeat (2) @(negedge clk);
    fork
      begin
        for (int i = 0; i < 6; i++) send_tx(16'($urandom), pen, kind, 0, 1'b0);
      end
      begin
        for (int j = 0; j < 8; j++)
          send_rx(8'($urandom), pen, kind, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      end
    join

    // Reset in the middle of a TX and an RX frame.
    ftc = ft_count;
    frc = fr_count;
    @(negedge clk);
    data = 16'($urandom);
    parity_en = 1'b0;
    start = 1'b1;
    tx_q.push_back(model_tx(data[7:0], 1'b0, 1'b0));
    rxd = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_txd", {31'b0, txd}, 32'd1);
    check("midrst_flag", {31'b0, flag}, 32'd0);
    check("midrst_ft", {31'b0, ft}, 32'd0);
    check("midrst_fr", {31'b0, fr}, 32'd0);
    check("midrst_hist", {r1, r2, r3, r4}, 32'd0);
    hist = '{default: 8'h00};
    rxd = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    check("midrst_no_ft", ft_count, ftc);
    check("midrst_no_fr", fr_count, frc);
    check("midrst_idle_txd", {31'b0, txd}, 32'd1);

    repeat (2 * CPB) @(negedge clk);
    check("ft_total", ft_count, tx_done_exp);
    check("fr_total", fr_count, rx_good_exp);
    check("tx_queue_drained", tx_q.size(), 32'd0);
    check("rx_queue_drained", rx_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
